// File: rtl/instr_fetch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_arbiter: round-robin sharing of one 1-cycle-latency          |
// | instruction RAM read port among NUM_CORES fetchers.                      |
// | Option: IFA_FIXED_PRIO_EN selects fixed priority (core 0 highest).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_fetch_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        valid,
    output logic [NUM_CORES*DATA_W-1:0] instr,
    output logic                        mem_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int              c_ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [c_ID_W:0] c_NUM  = (c_ID_W + 1)'(NUM_CORES);

    logic [NUM_CORES-1:0]        r_inflight;
    logic [NUM_CORES-1:0]        r_valid;
    logic [NUM_CORES*DATA_W-1:0] r_instr;
    logic                        r_s1_vld;
    logic [c_ID_W-1:0]           r_s1_id;

    logic [NUM_CORES-1:0]        w_elig;
    logic [NUM_CORES-1:0]        w_clr;
    logic [c_ID_W-1:0]           w_rr_ptr;
    logic [c_ID_W-1:0]           w_win;
    logic [c_ID_W:0]             w_idx;
    logic                        w_found;

    assign w_elig = req & ~r_inflight;

    // Rotating scan from the pointer; one extra index bit absorbs the wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_idx = {1'b0, w_rr_ptr} + (c_ID_W + 1)'(k);
            if (w_idx >= c_NUM) begin
                w_idx = w_idx - c_NUM;
            end
            if (!w_found && w_elig[w_idx[c_ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_ID_W-1:0];
            end
        end
        // Combinational outputs must read zero while reset is held.
        if (!reset_n) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        gnt      = '0;
        mem_addr = '0;
        if (w_found) begin
            gnt[w_win] = 1'b1;
            mem_addr   = addr[w_win*ADDR_W +: ADDR_W];
        end
    end

    assign mem_en = w_found;

    always_comb begin
        w_clr = '0;
        if (r_s1_vld) begin
            w_clr[r_s1_id] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_id    <= '0;
            r_valid    <= '0;
            r_instr    <= '0;
        end else begin
            r_inflight <= (r_inflight & ~w_clr) | gnt;
            r_s1_vld   <= w_found;
            if (w_found) begin
                r_s1_id <= w_win;
            end
            r_valid <= w_clr;
            if (r_s1_vld) begin
                r_instr[r_s1_id*DATA_W +: DATA_W] <= mem_rdata;
            end
        end
    end

`ifdef IFA_FIXED_PRIO_EN
    assign w_rr_ptr = '0;
`else
    logic [c_ID_W-1:0] r_rr_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_win == c_ID_W'(NUM_CORES - 1)) ? '0 : w_win + c_ID_W'(1);
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`endif

    assign valid = r_valid;
    assign instr = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_fetch_arbiter: table-driven bench with a grant/valid scoreboard |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            clock   = 1'b0;
    logic            reset_n = 1'b1;
    logic [N-1:0]    req     = '0;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    valid;
    logic [N*DW-1:0] instr;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata = '0;

    logic [AW-1:0]   core_addr [N] = '{8'h03, 8'h14, 8'h05, 8'h06};

    assign addr = {core_addr[3], core_addr[2], core_addr[1], core_addr[0]};

    always #5 clock = ~clock;

    // Registered-read RAM with ram[a] = a ^ 8'hA5.
    always @(posedge clock) begin
        if (mem_en) begin
            mem_rdata <= mem_addr ^ 8'hA5;
        end
    end

    instr_fetch_arbiter #(
        .NUM_CORES (N),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .addr      (addr),
        .gnt       (gnt),
        .valid     (valid),
        .instr     (instr),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        bit           rst_before;
        bit           rst_during;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
    } vec_t;

    typedef struct {
        int           due;
        int           id;
        logic [DW-1:0] data;
    } exp_t;

    vec_t            vecs[$];
    exp_t            sb[$];
    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    logic [N*DW-1:0] exp_instr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input bit rb, input bit rd, input logic [N-1:0] r, input logic [N-1:0] g);
        vec_t v;
        v.rst_before = rb;
        v.rst_during = rd;
        v.req        = r;
        v.gnt        = g;
        vecs.push_back(v);
    endtask

    function automatic int idx_of(input logic [N-1:0] g);
        int id;
        id = 0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) id = i;
        end
        return id;
    endfunction

    task automatic do_reset(input logic [N-1:0] r);
        req     = r;
        reset_n = 1'b0;
        #4;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        sb.delete();
        exp_instr = '0;
    endtask

    task automatic check_scoreboard();
        exp_t e;
        if (valid != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("valid_time", cyc, e.due);
                chk("valid", 32'(valid), 32'(4'b0001 << e.id));
                exp_instr[e.id*DW +: DW] = e.data;
                chk("instr", instr, exp_instr);
            end
        end else begin
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("missing_valid", 32'(valid), 32'(4'b0001 << e.id));
            end
            chk("instr_hold", instr, exp_instr);
        end
    endtask

    initial begin
`ifdef IFA_FIXED_PRIO_EN
        add(1, 0, 4'b1001, 4'b0001); add(0, 0, 4'b1001, 4'b1000);
        add(0, 0, 4'b1001, 4'b0001); add(0, 0, 4'b1001, 4'b1000);
        add(0, 0, 4'b0000, 4'b0000); add(0, 0, 4'b0000, 4'b0000);
        add(1, 0, 4'b1010, 4'b0010); add(0, 0, 4'b1010, 4'b1000);
        add(0, 0, 4'b1010, 4'b0010); add(0, 0, 4'b1010, 4'b1000);
        add(0, 0, 4'b0000, 4'b0000); add(0, 0, 4'b0000, 4'b0000);
`else
        // Single fetch from core 1.
        add(1, 0, 4'b0010, 4'b0010); add(0, 0, 4'b0000, 4'b0000);
        add(0, 0, 4'b0000, 4'b0000);
        // All cores requesting continuously from reset.
        add(1, 0, 4'b1111, 4'b0001); add(0, 0, 4'b1111, 4'b0010);
        add(0, 0, 4'b1111, 4'b0100); add(0, 0, 4'b1111, 4'b1000);
        add(0, 0, 4'b1111, 4'b0001); add(0, 0, 4'b1111, 4'b0010);
        add(0, 0, 4'b1111, 4'b0100); add(0, 0, 4'b1111, 4'b1000);
        add(0, 0, 4'b0000, 4'b0000); add(0, 0, 4'b0000, 4'b0000);
        // Pointer wrap: grant core 2, then cores 0 and 3 together.
        add(0, 0, 4'b0100, 4'b0100); add(0, 0, 4'b1001, 4'b1000);
        add(0, 0, 4'b0001, 4'b0001); add(0, 0, 4'b0000, 4'b0000);
        add(0, 0, 4'b0000, 4'b0000);
        // Core 2 alone holding req: inflight forces alternate cycles.
        add(0, 0, 4'b0100, 4'b0100); add(0, 0, 4'b0100, 4'b0000);
        add(0, 0, 4'b0100, 4'b0100); add(0, 0, 4'b0100, 4'b0000);
        add(0, 0, 4'b0100, 4'b0100); add(0, 0, 4'b0000, 4'b0000);
        add(0, 0, 4'b0000, 4'b0000);
`endif
        // Reset while a fetch is in flight.
        add(1, 0, 4'b0001, 4'b0001); add(0, 1, 4'b0001, 4'b0000);
        add(0, 0, 4'b1111, 4'b0001); add(0, 0, 4'b0000, 4'b0000);
        add(0, 0, 4'b0000, 4'b0000);

        @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset(vecs[i].req);
            req = vecs[i].req;
            if (vecs[i].rst_during) reset_n = 1'b0;
            #4;
            cyc++;
            if (vecs[i].rst_during) begin
                sb.delete();
                exp_instr = '0;
            end
            check_scoreboard();
            chk("gnt", 32'(gnt), 32'(vecs[i].gnt));
            chk("mem_en", 32'(mem_en), 32'(|vecs[i].gnt));
            if (vecs[i].gnt != '0) begin
                exp_t e;
                e.due  = cyc + 2;
                e.id   = idx_of(vecs[i].gnt);
                e.data = core_addr[e.id] ^ 8'hA5;
                chk("mem_addr", 32'(mem_addr), 32'(core_addr[e.id]));
                sb.push_back(e);
            end else begin
                chk("mem_addr_idle", 32'(mem_addr), 32'h0);
            end
            @(posedge clock);
            #1;
            if (vecs[i].rst_during) reset_n = 1'b1;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
